// File: rtl/ber_report_pkg.sv
// ber_report_pkg: shared constants, FSM encoding and frame byte mux
// for the BER UART reporter.
package ber_report_pkg;

  localparam logic [7:0] FRAME_HEADER = 8'hA5;
  localparam int         FRAME_LEN    = 19;
  localparam int         NB_BYTE_IDX  = 5;

  localparam logic [NB_BYTE_IDX-1:0] LAST_IDX =
    NB_BYTE_IDX'(FRAME_LEN - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    DATA,
    STOP
  } state_t;

  // Payload byte for index 0..17; counts go out MSB byte first.
  function automatic logic [7:0] frame_byte(
    input logic [NB_BYTE_IDX-1:0] idx,
    input logic [7:0]             tag,
    input logic [63:0]            samp,
    input logic [63:0]            err
  );
    logic [7:0] b;
    int         k;
    b = 8'h00;
    k = int'(idx);
    unique case (1'b1)
      (k == 0):             b = FRAME_HEADER;
      (k == 1):             b = tag;
      (k >= 2 && k <= 9):   b = samp[8*(9-k) +: 8];
      (k >= 10 && k <= 17): b = err[8*(17-k) +: 8];
      default:              b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// uart_tx_byte: 8N1 serializer with baud counter. i_start (when o_ready)
// begins a start bit; i_byte is sampled at the end of that start bit.
module uart_tx_byte #(
  parameter int BAUD_DIV    = 868,
  parameter int NB_BAUD_CNT = 10
) (
  input  logic       clk,
  input  logic       i_rst,
  input  logic [7:0] i_byte,
  input  logic       i_start,
  output logic       o_ready,
  output logic       o_tick,
  output logic       o_tx
);

  localparam logic [NB_BAUD_CNT-1:0] CNT_MAX =
    NB_BAUD_CNT'(BAUD_DIV - 1);

  logic                   active_q, active_d;
  logic [3:0]             bit_q, bit_d;
  logic [NB_BAUD_CNT-1:0] cnt_q, cnt_d;
  logic [7:0]             sh_q, sh_d;
  logic                   tx_q, tx_d;

  assign o_tick  = active_q && (cnt_q == CNT_MAX);
  // Ready in the last stop-bit cycle too, so bytes chain with no gap.
  assign o_ready = !active_q || (o_tick && bit_q == 4'd9);
  assign o_tx    = tx_q;

  always_comb begin
    active_d = active_q;
    bit_d    = bit_q;
    cnt_d    = cnt_q;
    sh_d     = sh_q;
    tx_d     = tx_q;
    if (active_q) begin
      cnt_d = o_tick ? '0 : cnt_q + 1'b1;
      if (o_tick) begin
        unique case (1'b1)
          (bit_q == 4'd0): begin
            tx_d  = i_byte[0];
            sh_d  = {1'b0, i_byte[7:1]};
            bit_d = 4'd1;
          end
          (bit_q >= 4'd1 && bit_q <= 4'd7): begin
            tx_d  = sh_q[0];
            sh_d  = {1'b0, sh_q[7:1]};
            bit_d = bit_q + 4'd1;
          end
          (bit_q == 4'd8): begin
            tx_d  = 1'b1;
            bit_d = 4'd9;
          end
          default: begin
            active_d = 1'b0;
            tx_d     = 1'b1;
            bit_d    = 4'd0;
          end
        endcase
      end
    end
    if (i_start && o_ready) begin
      active_d = 1'b1;
      cnt_d    = '0;
      bit_d    = 4'd0;
      tx_d     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge i_rst) begin
    if (!i_rst) begin
      active_q <= 1'b0;
      bit_q    <= 4'd0;
      cnt_q    <= '0;
      sh_q     <= 8'h00;
      tx_q     <= 1'b1;
    end else begin
      active_q <= active_d;
      bit_q    <= bit_d;
      cnt_q    <= cnt_d;
      sh_q     <= sh_d;
      tx_q     <= tx_d;
    end
  end

endmodule

// File: rtl/ber_uart_reporter.sv
// ber_uart_reporter: snapshots sample/error counts + tag on i_valid and
// sends a 19-byte frame on o_tx; o_busy/o_done/o_drop report handshake.
module ber_uart_reporter
  import ber_report_pkg::*;
#(
  parameter int NB_SAMPLES  = 64,
  parameter int NB_ERRORS   = 64,
  parameter int NB_TAG      = 8,
  parameter int BAUD_DIV    = 868,
  parameter int NB_BAUD_CNT = 10
) (
  input  logic                  clk,
  input  logic                  i_rst,
  input  logic                  i_valid,
  input  logic [NB_SAMPLES-1:0] i_samples,
  input  logic [NB_ERRORS-1:0]  i_errors,
  input  logic [NB_TAG-1:0]     i_tag,
  output logic                  o_tx,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_drop
);

  state_t                 state_q, state_d;
  logic [NB_BYTE_IDX-1:0] idx_q, idx_d;
  logic [2:0]             bit_cnt_q, bit_cnt_d;
  logic [63:0]            samp_q, samp_d;
  logic [63:0]            err_q, err_d;
  logic [NB_TAG-1:0]      tag_q, tag_d;
  logic [7:0]             byte_q, byte_d;
  logic [7:0]             csum_q, csum_d;
  logic                   done_q, done_d;
  logic                   drop_q, drop_d;

  logic tick;
  logic u_ready;
  logic u_start;

  always_ff @(posedge clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      bit_cnt_q <= '0;
      samp_q    <= '0;
      err_q     <= '0;
      tag_q     <= '0;
      byte_q    <= '0;
      csum_q    <= '0;
      done_q    <= 1'b0;
      drop_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      bit_cnt_q <= bit_cnt_d;
      samp_q    <= samp_d;
      err_q     <= err_d;
      tag_q     <= tag_d;
      byte_q    <= byte_d;
      csum_q    <= csum_d;
      done_q    <= done_d;
      drop_q    <= drop_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    bit_cnt_d = bit_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (i_valid) begin
          state_d = LOAD;
          idx_d   = '0;
        end
      end
      LOAD: state_d = START;
      START: begin
        if (tick) begin
          state_d   = DATA;
          bit_cnt_d = '0;
        end
      end
      DATA: begin
        if (tick) begin
          if (bit_cnt_q == 3'd7) state_d = STOP;
          else bit_cnt_d = bit_cnt_q + 3'd1;
        end
      end
      STOP: begin
        if (tick) begin
          if (idx_q == LAST_IDX) begin
            state_d = IDLE;
          end else begin
            state_d = LOAD;
            idx_d   = idx_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    samp_d = samp_q;
    err_d  = err_q;
    tag_d  = tag_q;
    byte_d = byte_q;
    csum_d = csum_q;
    done_d = (state_q == STOP) && tick && (idx_q == LAST_IDX);
    drop_d = i_valid && (state_q != IDLE);
    if (state_q == IDLE && i_valid) begin
      samp_d = 64'(i_samples);
      err_d  = 64'(i_errors);
      tag_d  = i_tag;
      csum_d = '0;
    end
    // LOAD overlaps the first start-bit cycle; the serializer
    // only samples byte_q when the start bit ends.
    if (state_q == LOAD) begin
      byte_d = (idx_q == LAST_IDX) ? csum_q
             : frame_byte(idx_q, 8'(tag_q), samp_q, err_q);
      csum_d = csum_q ^ byte_d;
    end
  end

  assign u_start = (state_d == LOAD) && u_ready;

  uart_tx_byte #(
    .BAUD_DIV    (BAUD_DIV),
    .NB_BAUD_CNT (NB_BAUD_CNT)
  ) u_tx (
    .clk     (clk),
    .i_rst   (i_rst),
    .i_byte  (byte_q),
    .i_start (u_start),
    .o_ready (u_ready),
    .o_tick  (tick),
    .o_tx    (o_tx)
  );

  assign o_busy = (state_q != IDLE);
  assign o_done = done_q;
  assign o_drop = drop_q;

endmodule

// File: doc/ber_uart_reporter.md
Name: ber_uart_reporter

Overview:
Downstream consumer of the TX FIR / BER chain. It snapshots the BER sample and error counts of one channel (I or Q) on request and serializes them as a fixed 19-byte frame over a UART TX line (8N1, LSB first). This gives a host PC the BER readout that the LEDs cannot show. One instance serves the I channel and one the Q channel, or a single instance is time-shared through the tag byte.

Parameters:
NB_SAMPLES, 64, width of sample-count input (multiple of 8)
NB_ERRORS, 64, width of error-count input (multiple of 8)
NB_TAG, 8, width of channel tag
BAUD_DIV, 868, clk cycles per UART bit (100 MHz / 115200)
NB_BAUD_CNT, 10, width of baud counter (must satisfy 2^NB_BAUD_CNT >= BAUD_DIV)

Ports:
clk  input  1  system clock, rising edge
i_rst  input  1  asynchronous, active-low reset
i_valid  input  1  snapshot request strobe
i_samples  input  NB_SAMPLES  sample count to report
i_errors  input  NB_ERRORS  error count to report
i_tag  input  NB_TAG  channel id (0x00 = I, 0x01 = Q)
o_tx  output  1  UART serial line, idle high
o_busy  output  1  frame in progress
o_done  output  1  one-cycle pulse at end of frame
o_drop  output  1  one-cycle pulse when a request is rejected

Behaviour:
- Reset (i_rst low, asynchronous): o_tx=1, o_busy=0, o_done=0, o_drop=0. FSM goes to IDLE and all counters clear. A reset asserted mid-frame aborts the frame immediately; o_tx returns high with no partial stop bit.
- Accept: i_valid=1 while o_busy=0 latches i_samples, i_errors and i_tag into snapshot registers on that edge. o_busy=1 from the next cycle.
- Reject: i_valid=1 while o_busy=1 pulses o_drop for one cycle. The snapshot stays unchanged.
- Frame order, byte index 0..18:
  - byte 0: header 0xA5
  - byte 1: tag
  - bytes 2..9: samples, MSB byte first
  - bytes 10..17: errors, MSB byte first
  - byte 18: checksum = XOR of bytes 0..17, accumulated as bytes are loaded
- Input widths narrower than 64 are zero-extended to 8 bytes.
- Byte format: start bit (0), data bits d0..d7, stop bit (1). Each bit is held exactly BAUD_DIV cycles. Bytes follow back-to-back with no idle gap.
- Latency: the start bit of byte 0 appears on o_tx in the cycle after acceptance. A frame lasts 19*10*BAUD_DIV cycles.
- FSM states and transitions:
  - IDLE -> LOAD on accept
  - LOAD: selects the byte and updates the checksum; 1 cycle, absorbed into the start bit
  - START -> DATA
  - DATA: 8 bits
  - STOP -> LOAD if byte index < 18
  - STOP -> IDLE after byte 18
- Baud counter: counts 0..BAUD_DIV-1 and wraps. Advancing to the next bit happens on count == BAUD_DIV-1.
- End of frame: on the last cycle of the final stop bit, the FSM goes to IDLE. o_done=1 and o_busy=0 in the following cycle. An i_valid in that same cycle is accepted, which gives back-to-back frames with no idle bit.
- Simultaneous i_valid and reset: reset wins; nothing is latched.
- o_tx is registered, so there are no glitches.

Decomposition:
- Shared package ber_report_pkg:
  - FRAME_HEADER = 8'hA5
  - FRAME_LEN = 19
  - NB_BYTE_IDX = 5
  - state encoding: IDLE, LOAD, START, DATA, STOP
- Sub-module uart_tx_byte:
  - Contains the baud counter and the bit serializer.
  - Interface: i_byte, i_start, o_ready, o_tx.
- The top-level FSM owns the byte index, byte mux, checksum and handshake outputs.

Test Plan:
- Reset: hold i_rst=0 for 5 cycles -> o_tx=1, o_busy=0, o_done=0, o_drop=0 throughout.
- Single frame (BAUD_DIV=4): i_samples=0x400, i_errors=0x3, i_tag=0x01 -> bytes A5 01 00 00 00 00 00 00 04 00 00 00 00 00 00 00 00 03 A3. Frame spans 760 cycles; o_done pulses once.
- Bit timing: any frame with BAUD_DIV=4 -> each bit is exactly 4 cycles wide; the start bit begins 1 cycle after the accept edge.
- Drop: second i_valid 100 cycles into a frame -> o_drop pulses 1 cycle; the frame content is unchanged and no second frame is sent.
- Reset mid-frame: assert i_rst during byte 5 -> o_tx goes high asynchronously and o_busy=0. A new i_valid afterwards sends a complete fresh frame starting with 0xA5.
- Back-to-back: i_valid in the o_done cycle with i_tag=0x00, errors=0 -> second frame starts immediately with checksum 0xA5^0x00^0x04 = 0xA1 (samples=0x400).
